// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: RP5C01-style BCD time/date keeper driven by a 10 Hz enable, nibble register interface
module rtc_timekeeper (
  input  logic       clk21m,
  input  logic       reset_n,
  input  logic       ce_10hz,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       sec_tick
);
  logic [3:0] sec_u, min_u, hr_u, day_u, mon_u, yr_u, yr_t, mode, presc;
  logic [2:0] sec_t, min_t, dow;
  logic [1:0] hr_t, day_t;
  logic       mon_t, pending;
  logic       te, tick_due, do_tick, clr;
  logic       su_c, st_c, mu_c, mt_c, hr_wrap, dc, day_end, mc, mon_end, yc, leap;
  logic [7:0] mon, day, yb, last;
  logic [3:0] n_su, n_mu, n_hu, n_du, n_mou, n_yu, n_yt;
  logic [2:0] n_st, n_mt, n_dow;
  logic [1:0] n_ht, n_dt;
  logic       n_mot;
  assign te       = mode[3];
  assign tick_due = ce_10hz & te & (presc >= 4'd9);
  assign do_tick  = te & (tick_due | pending) & ~wr;
  assign clr      = wr & (addr == 4'hF) & din[0];
  assign su_c = sec_u >= 4'd9;
  assign n_su = su_c ? 4'd0 : sec_u + 4'd1;
  assign st_c = su_c & (sec_t >= 3'd5);
  assign n_st = su_c ? (sec_t >= 3'd5 ? 3'd0 : sec_t + 3'd1) : sec_t;
  assign mu_c = st_c & (min_u >= 4'd9);
  assign n_mu = st_c ? (min_u >= 4'd9 ? 4'd0 : min_u + 4'd1) : min_u;
  assign mt_c = mu_c & (min_t >= 3'd5);
  assign n_mt = mu_c ? (min_t >= 3'd5 ? 3'd0 : min_t + 3'd1) : min_t;
  // any hour at or beyond 23 rolls over, so corrupt presets self-heal
  assign hr_wrap = (hr_t > 2'd2) | ((hr_t == 2'd2) & (hr_u >= 4'd3));
  assign dc   = mt_c & hr_wrap;
  assign n_hu = mt_c ? ((hr_wrap | (hr_u >= 4'd9)) ? 4'd0 : hr_u + 4'd1) : hr_u;
  assign n_ht = mt_c ? (hr_wrap ? 2'd0 : (hr_u >= 4'd9 ? hr_t + 2'd1 : hr_t)) : hr_t;
  assign n_dow = dc ? (dow >= 3'd6 ? 3'd0 : dow + 3'd1) : dow;
  assign mon  = {3'b0, mon_t, mon_u};
  assign day  = {2'b0, day_t, day_u};
  assign yb   = {4'b0, yr_t} * 8'd10 + {4'b0, yr_u};
  assign leap = yb[1:0] == 2'd0;
  assign last = (mon == 8'h04 || mon == 8'h06 || mon == 8'h09 || mon == 8'h11) ? 8'h30 :
                (mon == 8'h02) ? (leap ? 8'h29 : 8'h28) : 8'h31;
  assign day_end = day >= last;
  assign mc    = dc & day_end;
  assign n_du  = dc ? (day_end ? 4'd1 : (day_u >= 4'd9 ? 4'd0 : day_u + 4'd1)) : day_u;
  assign n_dt  = dc ? (day_end ? 2'd0 : (day_u >= 4'd9 ? day_t + 2'd1 : day_t)) : day_t;
  assign mon_end = mon >= 8'h12;
  assign yc    = mc & mon_end;
  assign n_mou = mc ? (mon_end ? 4'd1 : (mon_u >= 4'd9 ? 4'd0 : mon_u + 4'd1)) : mon_u;
  assign n_mot = mc ? (mon_end ? 1'b0 : (mon_u >= 4'd9 ? ~mon_t : mon_t)) : mon_t;
  assign n_yu  = yc ? (yr_u >= 4'd9 ? 4'd0 : yr_u + 4'd1) : yr_u;
  assign n_yt  = (yc & (yr_u >= 4'd9)) ? (yr_t >= 4'd9 ? 4'd0 : yr_t + 4'd1) : yr_t;
  always_comb begin
    dout = 4'h0;
    case (addr)
      4'h0: dout = sec_u;
      4'h1: dout = {1'b0, sec_t};
      4'h2: dout = min_u;
      4'h3: dout = {1'b0, min_t};
      4'h4: dout = hr_u;
      4'h5: dout = {2'b0, hr_t};
      4'h6: dout = {1'b0, dow};
      4'h7: dout = day_u;
      4'h8: dout = {2'b0, day_t};
      4'h9: dout = mon_u;
      4'hA: dout = {3'b0, mon_t};
      4'hB: dout = yr_u;
      4'hC: dout = yr_t;
      4'hD: dout = mode;
      default: dout = 4'h0;
    endcase
  end
  always_ff @(posedge clk21m or negedge reset_n)
    if (!reset_n) begin
      {sec_u, sec_t, min_u, min_t, hr_u, hr_t, dow} <= '0;
      {day_t, mon_t, yr_u, yr_t} <= '0;
      day_u    <= 4'd1;
      mon_u    <= 4'd1;
      mode     <= 4'h8;
      presc    <= 4'd0;
      pending  <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      presc    <= clr ? 4'd0 : (te & ce_10hz) ? (presc >= 4'd9 ? 4'd0 : presc + 4'd1) : presc;
      // a tick colliding with a write is held and applied to the written values
      pending  <= ~clr & (tick_due | pending) & ~do_tick;
      sec_tick <= do_tick;
      if (wr) begin
        case (addr)
          4'h0: sec_u <= din;
          4'h1: sec_t <= din[2:0];
          4'h2: min_u <= din;
          4'h3: min_t <= din[2:0];
          4'h4: hr_u  <= din;
          4'h5: hr_t  <= din[1:0];
          4'h6: dow   <= din[2:0];
          4'h7: day_u <= din;
          4'h8: day_t <= din[1:0];
          4'h9: mon_u <= din;
          4'hA: mon_t <= din[0];
          4'hB: yr_u  <= din;
          4'hC: yr_t  <= din;
          4'hD: mode  <= din;
          default: ;
        endcase
      end else if (do_tick) begin
        {sec_u, sec_t, min_u, min_t} <= {n_su, n_st, n_mu, n_mt};
        {hr_u, hr_t, dow}            <= {n_hu, n_ht, n_dow};
        {day_u, day_t, mon_u, mon_t} <= {n_du, n_dt, n_mou, n_mot};
        {yr_u, yr_t}                 <= {n_yu, n_yt};
      end
    end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Battery-backed real-time clock core for the MSX peripheral area. It sits directly downstream of the system clock-enable generator and consumes its 10 Hz enable to keep BCD time and date: seconds, minutes, 24-hour hours, day-of-week, day, month and two-digit year. The register map is RP5C01-style with 4-bit nibbles. The CPU-side I/O decoder reads and writes it through a nibble interface.

## Interface
Parameters: none.

- clk21m  in  1  system clock, 21.477 MHz
- reset_n  in  1  asynchronous active-low reset; all state is initialised while low
- ce_10hz  in  1  one-clk21m-cycle enable at 10 Hz from the clock generator
- wr  in  1  register write strobe, one cycle, sampled on clk21m
- addr  in  4  register index 0x0–0xF
- din  in  4  write data
- dout  out  4  read data for `addr`, combinational from registers
- sec_tick  out  1  one-cycle pulse on each seconds increment

## Operation
Register map (unused bits read 0; writes are masked to field width):
- 0 sec units [3:0]; 1 sec tens [2:0]
- 2 min units [3:0]; 3 min tens [2:0]
- 4 hour units [3:0]; 5 hour tens [1:0]
- 6 day-of-week [2:0], range 0–6
- 7 day units [3:0]; 8 day tens [1:0]
- 9 month units [3:0]; A month tens [0]
- B year units [3:0]; C year tens [3:0]
- D mode: bit3 = TE (timer enable); bits[2:0] are stored and read back
- E reads 0, writes ignored
- F write-only: bit0 = 1 clears the prescaler; reads 0

Prescaler:
- 4-bit, counts ce_10hz pulses while TE = 1.
- When a ce_10hz pulse arrives with prescaler = 9, the prescaler goes to 0 and a second tick is raised.
- When TE = 0, the prescaler and all time fields hold.

Second tick (full carry chain, applied in one edge):
- Units digit ≥ 9 → 0 with carry; otherwise +1. The same rule applies to every units field.
- Seconds and minutes: tens ≥ 5 with carry-in → 0, carry out.
- Hours: 23 → 00 with day carry. Any hour value ≥ 23 (BCD tens:units) also wraps to 00.
- Day carry:
  - dow ≥ 6 → 0, otherwise +1.
  - If day ≥ last day of the month, day → 01 and month carry; otherwise day +1 (BCD).
- Last day of month:
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for 04, 06, 09, 11.
  - Feb: 29 if year mod 4 = 0, else 28. Year is evaluated as binary (10·tens + units).
  - Any other (invalid) month uses 31.
- Month carry: month ≥ 12 → 01 and year +1 (BCD). Year 99 → 00.

CPU writes:
- A write updates the addressed field in the edge after wr.
- If a second tick is due in the same cycle as wr, the tick is deferred one cycle via a pending flag and applied to the post-write values.
- A write to F with bit0 = 1 clears the prescaler and any pending tick.

## Timing
- Reset values: time 00:00:00; day 01, month 01, year 00; dow 0; mode 0x8 (TE = 1); prescaler 0; pending 0; sec_tick 0; dout = register at addr.
- dout has zero-cycle latency from addr; it reflects a write on the cycle after wr.
- sec_tick is high for exactly one cycle: the cycle after the edge where the fields advanced.
- Undeferred tick: the fields update on the same edge that samples ce_10hz. With deferral, the update lands one edge later.
- If reset_n deasserts mid-second, counting restarts from prescaler 0. The first tick arrives on the 10th subsequent ce_10hz.

## Test plan
- Reset, then 10 ce_10hz pulses → sec units = 1, sec_tick pulses once; after 9 pulses sec units is still 0.
- Preset 23:59:59, day 31, month 12, year 99, dow 6; one tick → 00:00:00, day 01, month 01, year 00, dow 0.
- Preset 02/28 with year 24 and 23:59:59; tick → 02/29. Repeat with year 23 → 03/01. Preset 04/30 → 05/01.
- Write D = 0x0, then 30 ce_10hz → all fields unchanged. Write D = 0x8, then 10 pulses → sec +1.
- Assert wr to sec units = 5 in the same cycle a tick is due → next cycle sec = 06, and sec_tick pulses one cycle later than undeferred.
- After 7 ce_10hz, write F = 0x1 → 10 more pulses are needed before the next tick. Pull reset_n low mid-count → all outputs return to reset values immediately.
